fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of a FIFO controller among NUM_REQ requesters.
- Grants one requester at a time and holds that grant for a bounded burst of up to MAX_BURST words.
- Uses the FIFO overflow/full indication as back-pressure, so the FIFO is never written while full.
- Sits in the write clock domain, directly in front of the FIFO write pointer control.

---
 rtl/fifo_wr_arbiter.sv | 143 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for a shared FIFO write port. A grant is held for up to
// MAX_BURST accepted words, and fifo_full acts as back-pressure.
module fifo_wr_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int OW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BW         = $clog2(MAX_BURST + 1)
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          fifo_full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic                          busy,
  output logic                          state_dbg,
  output logic [OW-1:0]                 last_owner_dbg,
  output logic [BW-1:0]                 burst_cnt_dbg
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Handshake: a word from requester i is consumed in any cycle where
  // ack[i] is high, i.e. gnt[i] & req[i] & ~fifo_full. The requester holds
  // req[i] and its data slice stable until that cycle.

  state_t                state, state_nxt;
  logic [OW-1:0]         owner, owner_nxt;
  logic [OW-1:0]         last_owner, last_owner_nxt;
  logic [NUM_REQ-1:0]    gnt_nxt;
  logic [BW-1:0]         burst_cnt, burst_cnt_nxt;

  logic                  pick_valid;
  logic [OW-1:0]         pick;
  logic [OW-1:0]         cand_idx;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  accept;

  // Rotating priority: search upward from the requester after last_owner.
  always_comb begin
    pick_valid = 1'b0;
    pick       = last_owner;
    cand_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = OW'((int'(last_owner) + k) % NUM_REQ);
      if (!pick_valid && req[cand_idx]) begin
        pick_valid = 1'b1;
        pick       = cand_idx;
      end
    end
  end

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == OW'(i)) begin
        owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OW'(NUM_REQ - 1);
      gnt        <= '0;
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      gnt        <= gnt_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    gnt_nxt        = gnt;
    burst_cnt_nxt  = burst_cnt;
    accept         = 1'b0;
    ack            = '0;
    fifo_wr        = 1'b0;
    fifo_wdata     = '0;

    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt     = GRANT;
          owner_nxt     = pick;
          gnt_nxt       = '0;
          gnt_nxt[pick] = 1'b1;
          burst_cnt_nxt = '0;
        end
      end

      GRANT: begin
        fifo_wdata = owner_data;
        accept     = req[owner] & ~fifo_full;
        fifo_wr    = accept;
        ack        = gnt & {NUM_REQ{accept}};
        if (accept) begin
          burst_cnt_nxt = burst_cnt + BW'(1);
        end
        // A dropped request or the last word of the burst ends the grant;
        // a full FIFO alone just stalls with the grant held.
        if (!req[owner] || (accept && burst_cnt == BW'(MAX_BURST - 1))) begin
          state_nxt      = IDLE;
          last_owner_nxt = owner;
          gnt_nxt        = '0;
        end
      end

      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  assign busy           = (state == GRANT);
  assign state_dbg      = state;
  assign last_owner_dbg = last_owner;
  assign burst_cnt_dbg  = burst_cnt;

`ifndef SYNTHESIS
  a_gnt_onehot : assert property (@(posedge aclk) disable iff (!aresetn) $onehot0(gnt));
  a_ack_subset : assert property (@(posedge aclk) disable iff (!aresetn) (ack & ~gnt) == '0);
  a_wr_ack     : assert property (@(posedge aclk) disable iff (!aresetn) fifo_wr == |ack);
  a_no_ovf     : assert property (@(posedge aclk) disable iff (!aresetn) !(fifo_wr && fifo_full));
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: fairness, bursts, stalls, early release
// and asynchronous reset, with hand-computed expectations.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;

  logic                          aclk;
  logic                          aresetn;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          fifo_full;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            ack;
  logic                          fifo_wr;
  logic [DATA_WIDTH-1:0]         fifo_wdata;
  logic                          busy;
  logic                          state_dbg;
  logic [1:0]                    last_owner_dbg;
  logic [2:0]                    burst_cnt_dbg;

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DATA_WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .req           (req),
    .req_data      (req_data),
    .fifo_full     (fifo_full),
    .gnt           (gnt),
    .ack           (ack),
    .fifo_wr       (fifo_wr),
    .fifo_wdata    (fifo_wdata),
    .busy          (busy),
    .state_dbg     (state_dbg),
    .last_owner_dbg(last_owner_dbg),
    .burst_cnt_dbg (burst_cnt_dbg)
  );

  // clock
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // inputs change just after the active edge, outputs are sampled at negedge
  task automatic nxt();
    @(posedge aclk);
    #1;
  endtask

  task automatic mid();
    @(negedge aclk);
  endtask

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic obs(input string tag, input logic [3:0] g, input logic w,
                     input logic [3:0] a, input logic [7:0] d);
    check({tag, "_gnt"},   32'(gnt),        32'(g));
    check({tag, "_wr"},    32'(fifo_wr),    32'(w));
    check({tag, "_ack"},   32'(ack),        32'(a));
    check({tag, "_wdata"}, 32'(fifo_wdata), 32'(d));
    check({tag, "_busy"},  32'(busy),       32'(|g));
  endtask

  function automatic logic [7:0] sl(input int i);
    return 8'((i + 1) * 17);
  endfunction

  task automatic do_reset();
    nxt();
    aresetn = 1'b0;
    nxt();
    aresetn = 1'b1;
  endtask

  initial begin
    logic [3:0] oh;
    aresetn   = 1'b0;
    req       = '0;
    fifo_full = 1'b0;
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};

    // ---- reset state
    nxt();
    nxt();
    aresetn = 1'b1;
    mid();
    obs("rst", 4'b0000, 1'b0, 4'b0000, 8'h00);
    check("rst_burst", 32'(burst_cnt_dbg),  32'd0);
    check("rst_last",  32'(last_owner_dbg), 32'd3);
    check("rst_state", 32'(state_dbg),      32'd0);

    // ---- single requester 0, full burst then bubble then re-grant
    nxt(); req = 4'b0001; mid();
    obs("t1_pre", 4'b0000, 1'b0, 4'b0000, 8'h00);
    for (int b = 0; b < MAX_BURST; b++) begin
      nxt(); mid();
      obs($sformatf("t1_w%0d", b), 4'b0001, 1'b1, 4'b0001, sl(0));
      check($sformatf("t1_cnt%0d", b), 32'(burst_cnt_dbg), 32'(b));
    end
    nxt(); mid();
    obs("t1_bubble", 4'b0000, 1'b0, 4'b0000, 8'h00);
    check("t1_last", 32'(last_owner_dbg), 32'd0);
    nxt(); mid();
    obs("t1_regrant", 4'b0001, 1'b1, 4'b0001, sl(0));
    nxt(); req = 4'b0000; mid();
    obs("t1_drop", 4'b0001, 1'b0, 4'b0000, sl(0));
    nxt(); mid();
    obs("t1_rel", 4'b0000, 1'b0, 4'b0000, 8'h00);

    // ---- all requesting: rotation 0,1,2,3,0 from a fresh reset
    do_reset();
    nxt(); req = 4'b1111; mid();
    obs("t2_pre", 4'b0000, 1'b0, 4'b0000, 8'h00);
    for (int g = 0; g < 5; g++) begin
      oh = 4'b0001 << (g % 4);
      for (int b = 0; b < MAX_BURST; b++) begin
        nxt(); mid();
        obs($sformatf("t2_g%0d_w%0d", g, b), oh, 1'b1, oh, sl(g % 4));
      end
      nxt();
      if (g == 4) req = 4'b0000;
      mid();
      obs($sformatf("t2_g%0d_bub", g), 4'b0000, 1'b0, 4'b0000, 8'h00);
    end

    // ---- requester 2 stalled by fifo_full for 3 cycles
    nxt(); req = 4'b0100; mid();
    obs("t3_pre", 4'b0000, 1'b0, 4'b0000, 8'h00);
    for (int s = 0; s < 3; s++) begin
      nxt(); fifo_full = 1'b1; mid();
      obs($sformatf("t3_stall%0d", s), 4'b0100, 1'b0, 4'b0000, sl(2));
      check($sformatf("t3_cnt%0d", s), 32'(burst_cnt_dbg), 32'd0);
    end
    for (int b = 0; b < MAX_BURST; b++) begin
      nxt(); fifo_full = 1'b0; mid();
      obs($sformatf("t3_w%0d", b), 4'b0100, 1'b1, 4'b0100, sl(2));
    end
    nxt(); req = 4'b0000; mid();
    obs("t3_bub", 4'b0000, 1'b0, 4'b0000, 8'h00);
    check("t3_last", 32'(last_owner_dbg), 32'd2);

    // ---- requester 1 drops request after 2 words
    nxt(); req = 4'b0010; mid();
    obs("t4_pre", 4'b0000, 1'b0, 4'b0000, 8'h00);
    nxt(); mid();
    obs("t4_w0", 4'b0010, 1'b1, 4'b0010, sl(1));
    nxt(); mid();
    obs("t4_w1", 4'b0010, 1'b1, 4'b0010, sl(1));
    nxt(); req = 4'b0000; mid();
    obs("t4_drop", 4'b0010, 1'b0, 4'b0000, sl(1));
    check("t4_cnt", 32'(burst_cnt_dbg), 32'd2);
    nxt(); mid();
    obs("t4_rel", 4'b0000, 1'b0, 4'b0000, 8'h00);
    check("t4_last", 32'(last_owner_dbg), 32'd1);

    // last_owner=1: 0110 must grant requester 2
    nxt(); req = 4'b0110; mid();
    nxt(); mid();
    obs("t4_rr2", 4'b0100, 1'b1, 4'b0100, sl(2));
    nxt(); req = 4'b0000; mid();
    nxt(); mid();
    check("t4_last2", 32'(last_owner_dbg), 32'd2);
    // last_owner=2: 0011 wraps to requester 0
    nxt(); req = 4'b0011; mid();
    nxt(); mid();
    obs("t4_rr0", 4'b0001, 1'b1, 4'b0001, sl(0));
    nxt(); req = 4'b0000; mid();
    nxt(); mid();
    obs("t4_rel0", 4'b0000, 1'b0, 4'b0000, 8'h00);

    // ---- asynchronous reset in the middle of owner 3's burst
    nxt(); req = 4'b1000; mid();
    nxt(); mid();
    obs("t5_w0", 4'b1000, 1'b1, 4'b1000, sl(3));
    nxt(); mid();
    obs("t5_w1", 4'b1000, 1'b1, 4'b1000, sl(3));
    nxt(); mid();
    check("t5_cnt", 32'(burst_cnt_dbg), 32'd2);
    aresetn = 1'b0;
    #1;
    obs("t5_async", 4'b0000, 1'b0, 4'b0000, 8'h00);
    check("t5_async_cnt",  32'(burst_cnt_dbg),  32'd0);
    check("t5_async_last", 32'(last_owner_dbg), 32'd3);
    nxt(); mid();
    obs("t5_held", 4'b0000, 1'b0, 4'b0000, 8'h00);
    nxt(); aresetn = 1'b1; mid();
    obs("t5_rel", 4'b0000, 1'b0, 4'b0000, 8'h00);
    nxt(); mid();
    obs("t5_regrant", 4'b1000, 1'b1, 4'b1000, sl(3));
    nxt(); req = 4'b0000; mid();
    nxt(); mid();
    obs("t5_end", 4'b0000, 1'b0, 4'b0000, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
